// File: rtl/descrambler_lock_ctrl.sv
// -----------------------------------------------------------------------------
// descrambler_lock_ctrl
//
// Lock-acquisition and loss-of-lock controller for a self-synchronising
// descrambler. It watches the descrambled symbol stream. While unlocked it
// commands seed reloads until LOCK_CNT consecutive idle matches are seen. It
// then declares lock. Once locked it monitors symbol errors per WINDOW-symbol
// window and drops lock when UNLOCK_ERR errors land inside one window.
//
// Optional feature macro: LOCK_CTRL_TIMEOUT_EN
//   When this macro is defined, a cycle counter bounds the time spent in
//   ACQUIRE to TIMEOUT cycles. On expiry it pulses io_timeout and falls back
//   to UNLOCKED. When the macro is undefined, ACQUIRE may persist indefinitely
//   and io_timeout is tied to 0.
//
// Parameters
//   LOCK_CNT    consecutive idle matches needed to lock       (2..255)
//   UNLOCK_ERR  errors within one window that force unlock    (1..WINDOW)
//   WINDOW      valid symbols per error-monitoring window     (2..255)
//   TIMEOUT     acquire timeout in clock cycles (macro build only)
//
// Ports
//   clock               rising-edge clock
//   reset               synchronous, active-high reset
//   io_rx_valid         a received symbol is present this cycle
//   io_rx_idle_match    symbol matched the idle pattern (qualified by valid)
//   io_rx_error         symbol was invalid (qualified by valid)
//   io_err_clr          clears io_err_count
//   io_seed_load        1-cycle pulse: reload descrambler state from the line
//   io_loc_rcvr_status  1 = descrambler locked
//   io_lock_state       0 UNLOCKED, 1 ACQUIRE, 2 LOCKED
//   io_err_count        saturating count of error symbols seen while locked
//   io_timeout          1-cycle pulse on acquire timeout
// -----------------------------------------------------------------------------
module descrambler_lock_ctrl #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 8,
    parameter int WINDOW     = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rx_valid,
    input  logic       io_rx_idle_match,
    input  logic       io_rx_error,
    input  logic       io_err_clr,
    output logic       io_seed_load,
    output logic       io_loc_rcvr_status,
    output logic [1:0] io_lock_state,
    output logic [7:0] io_err_count,
    output logic       io_timeout
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    // Elaboration-time guard on the supported parameter ranges.
    if (LOCK_CNT < 2 || LOCK_CNT > 255 ||
        WINDOW < 2 || WINDOW > 255 ||
        UNLOCK_ERR < 1 || UNLOCK_ERR > WINDOW ||
        TIMEOUT < 1) begin : g_bad_params
        $error("descrambler_lock_ctrl: parameter out of supported range");
    end

    localparam logic [7:0] LOCK_LAST_C  = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_ERR_C = 8'(UNLOCK_ERR);
    localparam logic [7:0] WINDOW_C     = 8'(WINDOW);

    lock_state_e state;
    logic [7:0]  match_cnt;
    logic [7:0]  win_cnt;
    logic [7:0]  win_err_cnt;
    logic [7:0]  err_count;
    logic        seed_load_q;
    logic        loc_status_q;

    // Symbol classification. Everything is qualified by io_rx_valid, so idle
    // cycles never move the symbol counters.
    logic       rx_good;
    logic       locked_err;
    logic [7:0] win_cnt_inc;
    logic [7:0] win_err_inc;
    logic       win_last;
    logic       err_limit;
    logic       to_hit;

    assign rx_good     = io_rx_valid & io_rx_idle_match & ~io_rx_error;
    assign locked_err  = (state == LOCKED) & io_rx_valid & io_rx_error;

    // The error on the last symbol of a window is counted before the wrap, so
    // the limit check uses the incremented values rather than the stored ones.
    assign win_cnt_inc = win_cnt + 8'd1;
    assign win_err_inc = win_err_cnt + {7'd0, io_rx_error};
    assign win_last    = (win_cnt_inc == WINDOW_C);
    assign err_limit   = io_rx_error & (win_err_inc == UNLOCK_ERR_C);

`ifdef LOCK_CTRL_TIMEOUT_EN
    localparam int              TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    // Counts every cycle spent in ACQUIRE, valid symbol or not.
    assign to_hit = (state == ACQUIRE) && ((to_cnt + TO_W'(1)) == TIMEOUT_C);

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            if (state == ACQUIRE && !to_hit)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;
        end
    end

    assign io_timeout = timeout_q;
`else
    assign to_hit     = 1'b0;
    assign io_timeout = 1'b0;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= UNLOCKED;
            match_cnt    <= 8'd0;
            win_cnt      <= 8'd0;
            win_err_cnt  <= 8'd0;
            err_count    <= 8'd0;
            seed_load_q  <= 1'b0;
            loc_status_q <= 1'b0;
        end else begin
            // Pulses default low; each event raises them for one cycle only.
            seed_load_q <= 1'b0;

            // Error count clear wins over an increment, but an error on the
            // same cycle still counts as the first one after the clear.
            if (io_err_clr)
                err_count <= locked_err ? 8'd1 : 8'd0;
            else if (locked_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            case (state)
                UNLOCKED: begin
                    if (io_rx_valid) begin
                        state       <= ACQUIRE;
                        match_cnt   <= 8'd0;
                        seed_load_q <= 1'b1;
                    end
                end

                ACQUIRE: begin
                    if (to_hit) begin
                        state     <= UNLOCKED;
                        match_cnt <= 8'd0;
                    end else if (rx_good) begin
                        if (match_cnt == LOCK_LAST_C) begin
                            state        <= LOCKED;
                            loc_status_q <= 1'b1;
                            match_cnt    <= 8'd0;
                            win_cnt      <= 8'd0;
                            win_err_cnt  <= 8'd0;
                        end else begin
                            match_cnt <= match_cnt + 8'd1;
                        end
                    end else if (io_rx_valid) begin
                        // Any bad symbol restarts the run from a fresh seed.
                        match_cnt   <= 8'd0;
                        seed_load_q <= 1'b1;
                    end
                end

                LOCKED: begin
                    if (io_rx_valid) begin
                        if (err_limit) begin
                            state        <= UNLOCKED;
                            loc_status_q <= 1'b0;
                            win_cnt      <= 8'd0;
                            win_err_cnt  <= 8'd0;
                        end else if (win_last) begin
                            win_cnt     <= 8'd0;
                            win_err_cnt <= 8'd0;
                        end else begin
                            win_cnt     <= win_cnt_inc;
                            win_err_cnt <= win_err_inc;
                        end
                    end
                end

                default: begin
                    state        <= UNLOCKED;
                    loc_status_q <= 1'b0;
                end
            endcase
        end
    end

    assign io_seed_load       = seed_load_q;
    assign io_loc_rcvr_status = loc_status_q;
    assign io_lock_state      = state;
    assign io_err_count       = err_count;

endmodule

// File: tb/tb_descrambler_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_descrambler_lock_ctrl
//
// Drives two instances of descrambler_lock_ctrl from one shared input stream:
//   main : default parameters (LOCK_CNT 16, UNLOCK_ERR 8, WINDOW 64)
//   sat  : LOCK_CNT 2, UNLOCK_ERR 255, WINDOW 255 (error-count saturation)
// A behavioural model of each instance is kept as plain integers; every
// falling edge compares all outputs of both instances against the model.
// Directed sequences add hand-computed literal expectations, then a long
// randomized run exercises the rest.
// -----------------------------------------------------------------------------
module tb_descrambler_lock_ctrl;

    localparam int M_LOCK = 16;
    localparam int M_UERR = 8;
    localparam int M_WIN  = 64;
    localparam int S_LOCK = 2;
    localparam int S_UERR = 255;
    localparam int S_WIN  = 255;
    localparam int TMO    = 1024;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic rx_valid = 1'b0;
    logic rx_idle  = 1'b0;
    logic rx_err   = 1'b0;
    logic err_clr  = 1'b0;

    logic       m_seed, m_status, m_tmo;
    logic [1:0] m_state;
    logic [7:0] m_errs;
    logic       s_seed, s_status, s_tmo;
    logic [1:0] s_state;
    logic [7:0] s_errs;

    always #5 clock = ~clock;

    descrambler_lock_ctrl #(
        .LOCK_CNT(M_LOCK), .UNLOCK_ERR(M_UERR), .WINDOW(M_WIN), .TIMEOUT(TMO)
    ) dut_main (
        .clock(clock), .reset(reset),
        .io_rx_valid(rx_valid), .io_rx_idle_match(rx_idle),
        .io_rx_error(rx_err), .io_err_clr(err_clr),
        .io_seed_load(m_seed), .io_loc_rcvr_status(m_status),
        .io_lock_state(m_state), .io_err_count(m_errs), .io_timeout(m_tmo)
    );

    descrambler_lock_ctrl #(
        .LOCK_CNT(S_LOCK), .UNLOCK_ERR(S_UERR), .WINDOW(S_WIN), .TIMEOUT(TMO)
    ) dut_sat (
        .clock(clock), .reset(reset),
        .io_rx_valid(rx_valid), .io_rx_idle_match(rx_idle),
        .io_rx_error(rx_err), .io_err_clr(err_clr),
        .io_seed_load(s_seed), .io_loc_rcvr_status(s_status),
        .io_lock_state(s_state), .io_err_count(s_errs), .io_timeout(s_tmo)
    );

    // ---------------------------------------------------------------- model
    typedef struct {
        int mode;   // 0 unlocked, 1 acquire, 2 locked
        int run;    // consecutive good idle symbols in acquire
        int wsym;   // symbols seen in the current window
        int werr;   // errors seen in the current window
        int errs;   // error symbols seen while locked, saturating
        int acq;    // cycles spent in acquire
        bit seed;
        bit status;
        bit tmo;
    } model_t;

    model_t mm;
    model_t ms;

    function automatic model_t step(model_t m, bit v, bit im, bit e, bit clr,
                                    int lock_cnt, int unlock_err, int window,
                                    int timeout);
        model_t n = m;
        bit locked_err = (m.mode == 2) && v && e;
        bit tmo_hit = 1'b0;
        n.seed = 1'b0;
        n.tmo  = 1'b0;
        if (clr)
            n.errs = locked_err ? 1 : 0;
        else if (locked_err && m.errs < 255)
            n.errs = m.errs + 1;
        case (m.mode)
            0: if (v) begin
                n.mode = 1;
                n.run  = 0;
                n.seed = 1'b1;
            end
            1: begin
`ifdef LOCK_CTRL_TIMEOUT_EN
                n.acq = m.acq + 1;
                tmo_hit = (n.acq == timeout);
`endif
                if (tmo_hit) begin
                    n.mode = 0;
                    n.run  = 0;
                    n.tmo  = 1'b1;
                end else if (v) begin
                    if (im && !e) begin
                        n.run = m.run + 1;
                        if (n.run == lock_cnt) begin
                            n.mode = 2;
                            n.run  = 0;
                            n.wsym = 0;
                            n.werr = 0;
                        end
                    end else begin
                        n.run  = 0;
                        n.seed = 1'b1;
                    end
                end
            end
            default: if (v) begin
                n.wsym = m.wsym + 1;
                n.werr = m.werr + (e ? 1 : 0);
                if (n.werr >= unlock_err) begin
                    n.mode = 0;
                    n.wsym = 0;
                    n.werr = 0;
                end else if (n.wsym == window) begin
                    n.wsym = 0;
                    n.werr = 0;
                end
            end
        endcase
        if (n.mode != 1)
            n.acq = 0;
        if (timeout < 0)
            n.acq = 0;
        n.status = (n.mode == 2);
        return n;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            mm = '{default: 0};
            ms = '{default: 0};
        end else begin
            mm = step(mm, rx_valid, rx_idle, rx_err, err_clr, M_LOCK, M_UERR, M_WIN, TMO);
            ms = step(ms, rx_valid, rx_idle, rx_err, err_clr, S_LOCK, S_UERR, S_WIN, TMO);
        end
    end

    // ------------------------------------------------------------ checking
    int n_cmp  = 0;
    int n_bad  = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("main.lock_state", 32'(m_state),  32'(mm.mode));
            check("main.status",     32'(m_status), 32'(mm.status));
            check("main.seed_load",  32'(m_seed),   32'(mm.seed));
            check("main.err_count",  32'(m_errs),   32'(mm.errs));
            check("main.timeout",    32'(m_tmo),    32'(mm.tmo));
            check("sat.lock_state",  32'(s_state),  32'(ms.mode));
            check("sat.status",      32'(s_status), 32'(ms.status));
            check("sat.seed_load",   32'(s_seed),   32'(ms.seed));
            check("sat.err_count",   32'(s_errs),   32'(ms.errs));
            check("sat.timeout",     32'(s_tmo),    32'(ms.tmo));
        end
    end

    // ------------------------------------------------------------ stimulus
    // Inputs change right after a falling edge; the task returns at the next
    // falling edge, where the outputs reflect the symbol just driven.
    task automatic drive(input bit v, input bit im, input bit e, input bit clr);
        rx_valid = v;
        rx_idle  = im;
        rx_err   = e;
        err_clr  = clr;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset  = 1'b0;
        cmp_en = 1'b1;
    endtask

    // One seeding symbol followed by LOCK_CNT good idle matches.
    task automatic lock_main();
        repeat (M_LOCK + 1) drive(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int erate;

        // Reset state, then lock with a clean idle stream.
        do_reset();
        check("reset.lock_state", 32'(m_state),  0);
        check("reset.status",     32'(m_status), 0);
        check("reset.err_count",  32'(m_errs),   0);
        check("reset.seed_load",  32'(m_seed),   0);
        check("reset.timeout",    32'(m_tmo),    0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("lock.seed_after_first", 32'(m_seed),  1);
        check("lock.acquire_state",    32'(m_state), 1);
        repeat (M_LOCK - 1) drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("lock.seed_single",   32'(m_seed),   0);
        check("lock.not_yet_15",    32'(m_status), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("lock.state_locked",  32'(m_state),  2);
        check("lock.status_high",   32'(m_status), 1);

        // Eight errors spaced 5 apart inside one window: unlock after 8th.
        for (int i = 1; i <= 40; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), (i % 5 == 0), 1'b0);
            if (i == 35)
                check("unlock.still_locked_7", 32'(m_state), 2);
        end
        check("unlock.state",     32'(m_state),  0);
        check("unlock.status",    32'(m_status), 0);
        check("unlock.err_count", 32'(m_errs),   8);

        // Relock, then 7 errors per window for 3 windows: stays locked.
        lock_main();
        for (int w = 0; w < 3; w++)
            for (int i = 1; i <= M_WIN; i++)
                drive(1'b1, 1'($urandom_range(0, 1)), (i % 9 == 0), 1'b0);
        check("windows.locked",    32'(m_state),  2);
        check("windows.status",    32'(m_status), 1);
        check("windows.err_count", 32'(m_errs),   29);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("clear.err_count",   32'(m_errs),   0);

        // A single non-match in ACQUIRE reseeds and restarts the run.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("rerun.seed_on_miss", 32'(m_seed),  1);
        check("rerun.acquire",      32'(m_state), 1);
        repeat (M_LOCK - 1) drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("rerun.not_locked",   32'(m_state), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("rerun.locked",       32'(m_state), 2);

        // Seven errors in symbols 1..63 and the eighth on symbol 64.
        do_reset();
        lock_main();
        for (int i = 1; i <= M_WIN; i++) begin
            drive(1'b1, 1'b1, (i % 9 == 0) || (i == M_WIN), 1'b0);
            if (i == M_WIN - 1)
                check("lastsym.locked_63", 32'(m_state), 2);
        end
        check("lastsym.unlocked",  32'(m_state),  0);
        check("lastsym.status",    32'(m_status), 0);
        check("lastsym.err_count", 32'(m_errs),   8);

        // Saturation on the wide instance: 300 errors, then clear + error.
        do_reset();
        repeat (S_LOCK + 1) drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("sat.locked", 32'(s_state), 2);
        repeat (254) drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (46) drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("sat.still_locked", 32'(s_state), 2);
        check("sat.err_255",      32'(s_errs),  255);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("sat.clr_with_err", 32'(s_errs),  1);

        // Acquire with no matches at all for longer than TIMEOUT cycles.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (TMO - 1) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("tmo.before_limit",  32'(m_tmo),   0);
        check("tmo.acquire_hold",  32'(m_state), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef LOCK_CTRL_TIMEOUT_EN
        check("tmo.pulse",         32'(m_tmo),   1);
        check("tmo.unlocked",      32'(m_state), 0);
`else
        check("tmo.tied_low",      32'(m_tmo),   0);
        check("tmo.acquire_stays", 32'(m_state), 1);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("tmo.pulse_single",  32'(m_tmo),   0);

        // Randomized traffic with varying error density and rare resets.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 3)
                0:       erate = 1;
                1:       erate = 6;
                default: erate = 15;
            endcase
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 999) == 0) begin
                    do_reset();
                end else begin
                    bit v;
                    v = ($urandom_range(0, 7) != 0);
                    drive(v, ($urandom_range(0, 15) != 0),
                          ($urandom_range(0, 99) < erate),
                          v && ($urandom_range(0, 63) == 0));
                end
            end
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/descrambler_lock_ctrl.md
DESCRAMBLER_LOCK_CTRL -- requirements
Module: descrambler_lock_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16: consecutive idle matches needed to declare lock (range 2..255).
REQ-002 SHALL have parameter UNLOCK_ERR, default 8: symbol errors within one window that force loss of lock (range 1..WINDOW).
REQ-003 SHALL have parameter WINDOW, default 64: valid symbols per error-monitoring window (range 2..255).
REQ-004 SHALL have parameter TIMEOUT, default 1024: acquire-timeout limit in clock cycles (used only with the macro in REQ-026).
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset is synchronous and active-high.
REQ-007 io_rx_valid  input  1  one received symbol from the descrambler path is present this cycle.
REQ-008 io_rx_idle_match  input  1  descrambled symbol matched the expected idle pattern (meaningful only with io_rx_valid).
REQ-009 io_rx_error  input  1  descrambled symbol was invalid (meaningful only with io_rx_valid).
REQ-010 io_err_clr  input  1  clears io_err_count.
REQ-011 io_seed_load  output  1  one-cycle pulse commanding the descrambler to reload its state from the received symbol.
REQ-012 io_loc_rcvr_status  output  1  1 = descrambler locked; drives the descrambler's io_loc_rcvr_status.
REQ-013 io_lock_state  output  2  current state encoding: 0 UNLOCKED, 1 ACQUIRE, 2 LOCKED.
REQ-014 io_err_count  output  8  saturating count of io_rx_error symbols seen in LOCKED.
REQ-015 io_timeout  output  1  one-cycle pulse on acquire timeout.

Function
REQ-016 SHALL sample inputs only on cycles with io_rx_valid=1; cycles with io_rx_valid=0 SHALL change no counter except the timeout counter.
REQ-017 UNLOCKED: on the first valid symbol SHALL pulse io_seed_load next cycle and enter ACQUIRE with match count 0.
REQ-018 ACQUIRE: valid symbol with io_rx_idle_match=1 and io_rx_error=0 SHALL increment match count; any other valid symbol SHALL zero match count and pulse io_seed_load next cycle.
REQ-019 ACQUIRE: when the match count reaches LOCK_CNT, SHALL enter LOCKED and raise io_loc_rcvr_status on the following cycle (registered, one cycle after the LOCK_CNT-th match is sampled).
REQ-020 LOCKED: SHALL count valid symbols in a window counter and io_rx_error symbols in a window error counter; io_rx_idle_match SHALL be ignored.
REQ-021 LOCKED: when the window error counter reaches UNLOCK_ERR, SHALL enter UNLOCKED next cycle, dropping io_loc_rcvr_status in the same cycle the state changes.
REQ-022 Window wrap: on the WINDOW-th valid symbol both window counters SHALL clear; an error on that same symbol SHALL be counted and compared before clearing (reaching UNLOCK_ERR on the last symbol unlocks).
REQ-023 io_err_count SHALL increment per io_rx_error symbol in LOCKED, saturate at 255, and clear on io_err_clr; simultaneous clear and error SHALL yield 1.
REQ-024 io_seed_load and io_timeout SHALL never be high for more than one consecutive cycle per triggering event.

Reset
REQ-025 With reset=1 at a rising edge, SHALL enter UNLOCKED, zero all counters, and drive io_seed_load=0, io_loc_rcvr_status=0, io_lock_state=0, io_err_count=0, io_timeout=0 from the next cycle; reset mid-ACQUIRE or mid-LOCKED SHALL behave identically, with no pending pulses emitted.

Configuration
REQ-026 Macro LOCK_CTRL_TIMEOUT_EN defined: SHALL count cycles (valid or not) spent in ACQUIRE; on reaching TIMEOUT SHALL pulse io_timeout, return to UNLOCKED, and clear match count; counter clears on leaving ACQUIRE.
REQ-027 Macro LOCK_CTRL_TIMEOUT_EN undefined: no timeout counter SHALL exist, ACQUIRE persists indefinitely, io_timeout tied to 0.

Verification
REQ-028 Reset, then 16 valid idle matches -> io_seed_load pulse after first symbol, io_lock_state=2 and io_loc_rcvr_status=1 one cycle after 16th match.
REQ-029 In ACQUIRE, 10 matches then one non-match then 16 matches -> io_seed_load pulse after the non-match, lock only after the second run completes.
REQ-030 LOCKED, 8 errors spaced within 64 valid symbols -> io_loc_rcvr_status=0 and io_lock_state=0 the cycle after 8th error; 7 errors per window over 3 windows -> stays locked.
REQ-031 LOCKED, 7 errors in symbols 1..63 and 8th error on symbol 64 -> unlock; io_err_count=8.
REQ-032 300 errors with UNLOCK_ERR=255, WINDOW=255 -> io_err_count saturates at 255; io_err_clr with concurrent error -> 1.
REQ-033 LOCK_CTRL_TIMEOUT_EN defined, TIMEOUT=1024, no idle matches -> io_timeout pulse at cycle 1024 of ACQUIRE, return to UNLOCKED; undefined -> io_timeout stays 0.
